sblk_1: RTL and testbench

- Registered AND-then-stretch cell.
- Samples the bitwise AND of inputs a and b each clock and drives q2 high for two consecutive cycles per AND hit, acting as a pulse stretcher.
- Built as a two-register, nonblocking-update structure: combinational d1/d2 logic feeding registers q1/q2.
- Used as a leaf cell wherever a one-cycle coincidence of two qualifiers must be held for two cycles.

---
 rtl/sblk_1_pkg.sv | 7 +
 rtl/sblk_1.sv | 45 ++++
 tb/tb_sblk_1.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/sblk_1_pkg.sv
// Shared constants for the AND-then-stretch leaf cell.
//   SBLK_1_WIDTH : default lane count of a, b and q2
package sblk_1_pkg;

    localparam int unsigned SBLK_1_WIDTH = 1;

endpackage : sblk_1_pkg

// File: rtl/sblk_1.sv
// Registered AND-then-stretch cell.
// Each lane samples a & b on every rising clk edge and holds q2 high for two
// consecutive cycles per coincidence. Back-to-back hits merge into one
// contiguous high run of (hits + 1) cycles.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous reset, ACTIVE-HIGH despite the name; clears q1/q2
//   a     : qualifier A, WIDTH lanes
//   b     : qualifier B, WIDTH lanes
//   q2    : stretched, registered AND result (no combinational input path)
module sblk_1
    import sblk_1_pkg::*;
#(
    parameter int unsigned WIDTH = SBLK_1_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q2
);

    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [WIDTH-1:0] q1;

    // Current coincidence, merged with last cycle's coincidence to stretch it.
    always_comb begin
        d1 = a & b;
        d2 = d1 | q1;
    end

    // q1 remembers the previous coincidence; reset wins over data.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            q1 <= '0;
            q2 <= '0;
        end else begin
            q1 <= d1;
            q2 <= d2;
        end
    end

endmodule : sblk_1

// File: tb/tb_sblk_1.sv
// Self-checking bench for sblk_1: a 1-lane and a 4-lane instance share the
// clock and reset. Bit 0 of every vector drives the 1-lane instance.
module tb_sblk_1;

    typedef struct {
        logic       rst;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] e;
    } vec_t;

    typedef struct {
        logic [3:0] e;
        string      name;
    } sb_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] a4, b4, q2_4;
    logic       a1, b1, q2_1;

    int passed = 0;
    int total  = 0;

    vec_t vecs[$];
    sb_t  sb[$];
    logic [3:0] prev_and;

    sblk_1 #(.WIDTH(1)) u_dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .a    (a1),
        .b    (b1),
        .q2   (q2_1)
    );

    sblk_1 #(.WIDTH(4)) u_dut4 (
        .clk  (clk),
        .rst_n(rst_n),
        .a    (a4),
        .b    (b4),
        .q2   (q2_4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check4(input string name, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: q2_4 got %b required %b (t=%0t)", name, got, exp, $time);
    endtask

    task automatic check1(input string name, input logic got, input logic exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: q2_1 got %b required %b (t=%0t)", name, got, exp, $time);
    endtask

    // Drive one cycle of stimulus, queue the expectation, compare after the edge.
    task automatic apply(input logic r, input logic [3:0] av, input logic [3:0] bv,
                         input logic [3:0] e, input string name);
        sb_t s;
        rst_n = r;
        a4 = av;
        b4 = bv;
        a1 = av[0];
        b1 = bv[0];
        sb.push_back('{e, name});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total++;
            $display("FAIL %s: scoreboard empty, got none required one entry", name);
        end else begin
            s = sb.pop_front();
            check4(s.name, q2_4, s.e);
            check1(s.name, q2_1, s.e[0]);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        a4 = '0; b4 = '0; a1 = 1'b0; b1 = 1'b0;

        // reset with a=b=1, then release
        vecs.push_back('{1'b1, 4'hF, 4'hF, 4'h0});
        vecs.push_back('{1'b1, 4'hF, 4'hF, 4'h0});
        vecs.push_back('{1'b0, 4'hF, 4'hF, 4'hF});
        vecs.push_back('{1'b0, 4'hF, 4'hF, 4'hF});
        // single hit
        vecs.push_back('{1'b1, 4'h0, 4'h0, 4'h0});
        vecs.push_back('{1'b0, 4'hF, 4'hF, 4'hF});
        vecs.push_back('{1'b0, 4'hF, 4'h0, 4'hF});
        vecs.push_back('{1'b0, 4'hF, 4'h0, 4'h0});
        // no coincidence, both orientations and disjoint patterns
        vecs.push_back('{1'b0, 4'hF, 4'h0, 4'h0});
        vecs.push_back('{1'b0, 4'hF, 4'h0, 4'h0});
        vecs.push_back('{1'b0, 4'h0, 4'hF, 4'h0});
        vecs.push_back('{1'b0, 4'h0, 4'hF, 4'h0});
        vecs.push_back('{1'b0, 4'h5, 4'hA, 4'h0});
        // back-to-back: 3 hits -> 4 high cycles
        vecs.push_back('{1'b0, 4'hF, 4'hF, 4'hF});
        vecs.push_back('{1'b0, 4'hF, 4'hF, 4'hF});
        vecs.push_back('{1'b0, 4'hF, 4'hF, 4'hF});
        vecs.push_back('{1'b0, 4'h0, 4'h0, 4'hF});
        vecs.push_back('{1'b0, 4'h0, 4'h0, 4'h0});
        // reset mid-pulse, reset beats active data
        vecs.push_back('{1'b0, 4'hF, 4'hF, 4'hF});
        vecs.push_back('{1'b1, 4'hF, 4'hF, 4'h0});
        vecs.push_back('{1'b0, 4'h0, 4'h0, 4'h0});
        vecs.push_back('{1'b0, 4'h0, 4'h0, 4'h0});
        // lane independence
        vecs.push_back('{1'b0, 4'hA, 4'hC, 4'h8});
        vecs.push_back('{1'b0, 4'hA, 4'h0, 4'h8});
        vecs.push_back('{1'b0, 4'hA, 4'h0, 4'h0});
        vecs.push_back('{1'b0, 4'h3, 4'h1, 4'h1});
        vecs.push_back('{1'b0, 4'h6, 4'h6, 4'h7});
        vecs.push_back('{1'b0, 4'h0, 4'h0, 4'h6});
        vecs.push_back('{1'b0, 4'h0, 4'h0, 4'h0});

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst, vecs[i].a, vecs[i].b, vecs[i].e, $sformatf("vec%0d", i));
        end

        // Inputs toggled between edges must not reach q2 combinationally.
        a4 = 4'hF; b4 = 4'hF; a1 = 1'b1; b1 = 1'b1;
        #2;
        check4("no_comb_path", q2_4, 4'h0);
        check1("no_comb_path", q2_1, 1'b0);
        apply(1'b0, 4'h0, 4'h0, 4'h0, "glitch_ignored");

        // Random traffic against a reference of q2 = and[n] | and[n-1].
        prev_and = 4'h0;
        for (int i = 0; i < 60; i++) begin
            logic       r;
            logic [3:0] av, bv, cur, e;
            r  = ($urandom_range(0, 9) == 0);
            av = 4'($urandom_range(0, 15));
            bv = 4'($urandom_range(0, 15));
            cur = av & bv;
            e   = r ? 4'h0 : (cur | prev_and);
            prev_and = r ? 4'h0 : cur;
            apply(r, av, bv, e, $sformatf("rand%0d", i));
        end

        if (sb.size() != 0) begin
            total++;
            $display("FAIL sb_drain: %0d entries left, required 0", sb.size());
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_sblk_1
